ml_vec_dot_engine: RTL and testbench

Streaming signed fixed-point dot-product engine, the hardware successor to the MathLib vector math routines. It takes two vectors as a sequence of multi-lane beats and multiplies them lane by lane. Products are summed into a wide accumulator, and one scalar result is returned per vector pair over a valid/ready handshake. It sits beside the MathLib matrix/vector models, which act as its golden reference in verification.

---
 rtl/ml_vec_dot_engine.sv | 116 +++++++++++
 tb/tb_ml_vec_dot_engine.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/ml_vec_dot_engine.sv
// ml_vec_dot_engine: streaming signed multi-lane dot product, one scalar result per vector pair.
// Define ML_DOT_SAT_EN for a saturating accumulator with a sticky overflow flag; otherwise it wraps.
module ml_vec_dot_engine #(
  parameter int DATA_W = 16,
  parameter int LANES  = 4,
  parameter int LEN_W  = 8,
  parameter int ACC_W  = 40
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [LEN_W-1:0]          cfg_len,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*DATA_W-1:0]   a_data,
  input  logic [LANES*DATA_W-1:0]   b_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ACC_W-1:0]          out_data,
  output logic                      out_ovf,
  output logic                      busy
);

  localparam int PROD_W = 2*DATA_W + $clog2(LANES);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

  state_t                    state_q, state_d;
  logic [LEN_W-1:0]          len_q, cnt_q;
  logic signed [PROD_W-1:0]  prod_q, lane_sum;
  logic signed [ACC_W-1:0]   acc_q, acc_d, add_in, raw_sum;
  logic                      ovf_q, ovf_d;
  logic                      beat_fire, last_beat;

  assign beat_fire = (state_q == ACCUM) && in_valid;
  assign last_beat = beat_fire && (cnt_q == len_q - LEN_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)     state_d = ACCUM;
      ACCUM:   if (last_beat) state_d = DRAIN;
      DRAIN:                  state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Full-width signed lane products, sign-extended and summed into one beat total.
  always_comb begin
    logic signed [2*DATA_W-1:0] p;
    lane_sum = '0;
    p        = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      p        = $signed(a_data[i*DATA_W +: DATA_W]) * $signed(b_data[i*DATA_W +: DATA_W]);
      lane_sum = lane_sum + PROD_W'(p);
    end
  end

  assign add_in  = ACC_W'(prod_q);
  assign raw_sum = acc_q + add_in;

`ifdef ML_DOT_SAT_EN
  // Overflow only when both operands share a sign that the result lost.
  always_comb begin
    logic pos_ovf, neg_ovf;
    pos_ovf = !acc_q[ACC_W-1] && !add_in[ACC_W-1] &&  raw_sum[ACC_W-1];
    neg_ovf =  acc_q[ACC_W-1] &&  add_in[ACC_W-1] && !raw_sum[ACC_W-1];
    acc_d   = raw_sum;
    if (pos_ovf)      acc_d = {1'b0, {(ACC_W-1){1'b1}}};
    else if (neg_ovf) acc_d = {1'b1, {(ACC_W-1){1'b0}}};
    ovf_d   = ovf_q | pos_ovf | neg_ovf;
  end
`else
  always_comb begin
    acc_d = raw_sum;
    ovf_d = 1'b0;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q  <= '0;
      cnt_q  <= '0;
      prod_q <= '0;
      acc_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      prod_q <= beat_fire ? lane_sum : '0;
      if (state_q == IDLE) begin
        if (start) begin
          len_q <= (cfg_len == '0) ? LEN_W'(1) : cfg_len;
          cnt_q <= '0;
          acc_q <= '0;
          ovf_q <= 1'b0;
        end
      end else if (state_q == ACCUM || state_q == DRAIN) begin
        if (beat_fire) cnt_q <= cnt_q + LEN_W'(1);
        acc_q <= acc_d;
        ovf_q <= ovf_d;
      end
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_data  = acc_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_ml_vec_dot_engine.sv
// Scoreboard bench for ml_vec_dot_engine: directed vectors with hand-computed results.
`timescale 1ns/1ps
module tb_ml_vec_dot_engine;

  localparam int DATA_W = 16;
  localparam int LANES  = 4;
  localparam int LEN_W  = 8;
  localparam int ACC_W  = 40;
  localparam int BW     = LANES*DATA_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [LEN_W-1:0]  cfg_len = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [BW-1:0]     a_data = '0;
  logic [BW-1:0]     b_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [ACC_W-1:0]  out_data;
  logic              out_ovf;
  logic              busy;

  always #5 clk = ~clk;

  ml_vec_dot_engine #(
    .DATA_W(DATA_W),
    .LANES (LANES),
    .LEN_W (LEN_W),
    .ACC_W (ACC_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .cfg_len  (cfg_len),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_data   (a_data),
    .b_data   (b_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_ovf  (out_ovf),
    .busy     (busy)
  );

  typedef struct packed {
    logic signed [ACC_W-1:0] data;
    logic                    ovf;
  } res_t;

  res_t          sb_q[$];
  logic [BW-1:0] va[256];
  logic [BW-1:0] vb[256];
  int            checks = 0;
  int            passed = 0;

  function automatic void check(input string name, input logic [ACC_W-1:0] act, input logic [ACC_W-1:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  function automatic logic [BW-1:0] pk(input int l0, input int l1, input int l2, input int l3);
    return {16'(l3), 16'(l2), 16'(l1), 16'(l0)};
  endfunction

  // Monitor: every completed result handshake is matched against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_result", ACC_W'(sb_q.size()), ACC_W'(1));
      end else begin
        res_t e;
        e = sb_q.pop_front();
        check("result_data", out_data, ACC_W'(e.data));
        check("result_ovf", ACC_W'(out_ovf), ACC_W'(e.ovf));
      end
    end
  end

  task automatic run_vec(input string nm, input int cfg, input int nb, input bit bubbles,
                         input int hold, input logic signed [ACC_W-1:0] exp_d, input logic exp_o);
    res_t r;
    int   stalls;
    int   w;
    stalls    = 0;
    r.data    = exp_d;
    r.ovf     = exp_o;
    sb_q.push_back(r);
    out_ready = (hold == 0);
    @(posedge clk); #1;
    start   = 1'b1;
    cfg_len = LEN_W'(cfg);
    @(posedge clk); #1;
    start = 1'b0;
    check({nm, "_start_ready_busy"}, ACC_W'({in_ready, busy}), ACC_W'(2'b11));
    for (int i = 0; i < nb; i++) begin
      if (bubbles && i > 0) begin
        in_valid = 1'b0;
        start    = 1'b1;
        cfg_len  = LEN_W'(7);
        @(posedge clk); #1;
        start = 1'b0;
      end
      in_valid = 1'b1;
      a_data   = va[i];
      b_data   = vb[i];
      w = 0;
      while (!in_ready && w < 20) begin
        @(posedge clk); #1;
        w++;
        stalls++;
      end
      @(posedge clk); #1;
    end
    // Keep offering junk beats; none may be consumed after the last one.
    a_data = pk(999, 999, 999, 999);
    b_data = pk(999, 999, 999, 999);
    check({nm, "_stalls"}, ACC_W'(stalls), ACC_W'(0));
    check({nm, "_drain_in_ready"}, ACC_W'(in_ready), ACC_W'(0));
    @(posedge clk); #1;
    check({nm, "_out_valid_latency"}, ACC_W'(out_valid), ACC_W'(1));
    for (int h = 0; h < hold; h++) begin
      check({nm, "_hold_valid"}, ACC_W'(out_valid), ACC_W'(1));
      check({nm, "_hold_data"}, out_data, ACC_W'(exp_d));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    w = 0;
    while (out_valid && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    in_valid = 1'b0;
    check({nm, "_idle_after"}, ACC_W'({busy, out_valid}), ACC_W'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d passed=%0d", checks, passed);
    $fatal(1);
  end

  initial begin
    #2;
    check("reset_outputs", ACC_W'({in_ready, out_valid, out_ovf, busy}), ACC_W'(0));
    check("reset_out_data", out_data, ACC_W'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Basic: {1,2,3,4}.{1,1,1,1} + {5,6,7,8}.{-1,-1,-1,-1} = 10 - 26 = -16
    va[0] = pk(1, 2, 3, 4);       vb[0] = pk(1, 1, 1, 1);
    va[1] = pk(5, 6, 7, 8);       vb[1] = pk(-1, -1, -1, -1);
    run_vec("basic", 2, 2, 1'b0, 0, -40'sd16, 1'b0);

    // Bubbles, ignored starts, 5-cycle backpressure: -4 + 600 - 16 = 580
    va[0] = pk(1, -2, 3, -4);           vb[0] = pk(2, 2, 2, 2);
    va[1] = pk(100, 200, 300, 400);     vb[1] = pk(1, 0, -1, 2);
    va[2] = pk(-32768, 32767, 0, 5);    vb[2] = pk(1, 1, 7, -3);
    run_vec("bubbles", 3, 3, 1'b1, 5, 40'sd580, 1'b0);

    // Back-to-back beats: sum over k=1..4 of k*(1+2+3+4) = 100
    for (int k = 0; k < 4; k++) begin
      va[k] = pk(k+1, k+1, k+1, k+1);
      vb[k] = pk(1, 2, 3, 4);
    end
    run_vec("b2b", 4, 4, 1'b0, 0, 40'sd100, 1'b0);

    // Length zero is one beat: 4 * (3 * -2) = -24
    va[0] = pk(3, 3, 3, 3);  vb[0] = pk(-2, -2, -2, -2);
    run_vec("len0", 0, 1, 1'b0, 0, -40'sd24, 1'b0);

    // Extreme operands: 4 * (-32768 * 32767) = -4294836224
    va[0] = pk(-32768, -32768, -32768, -32768);
    vb[0] = pk(32767, 32767, 32767, 32767);
    run_vec("extreme", 1, 1, 1'b0, 2, -40'sd4294836224, 1'b0);

    // 128 beats of 4*2^30 reach exactly 2^39: one past the positive rail.
    for (int k = 0; k < 128; k++) begin
      va[k] = pk(-32768, -32768, -32768, -32768);
      vb[k] = pk(-32768, -32768, -32768, -32768);
    end
`ifdef ML_DOT_SAT_EN
    run_vec("ovf", 128, 128, 1'b0, 0, 40'sh7F_FFFF_FFFF, 1'b1);
`else
    run_vec("ovf", 128, 128, 1'b0, 0, 40'sh80_0000_0000, 1'b0);
`endif

    // Reset mid-vector: partial sum discarded, outputs clear immediately.
    @(posedge clk); #1;
    start   = 1'b1;
    cfg_len = LEN_W'(3);
    @(posedge clk); #1;
    start    = 1'b0;
    in_valid = 1'b1;
    a_data   = pk(50, 50, 50, 50);
    b_data   = pk(50, 50, 50, 50);
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("midreset_outputs", ACC_W'({in_ready, out_valid, out_ovf, busy}), ACC_W'(0));
    check("midreset_out_data", out_data, ACC_W'(0));
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    va[0] = pk(1, 1, 1, 1);  vb[0] = pk(1, 1, 1, 1);
    run_vec("post_reset", 1, 1, 1'b0, 0, 40'sd4, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", ACC_W'(sb_q.size()), ACC_W'(0));
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
